// File: rtl/ariane_regfile_ff.sv
// Flip-flop based multi-ported integer register file: 32 registers, combinational reads,
// synchronous writes where the highest-indexed enabled port wins an address conflict.
module ariane_regfile_ff #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NR_READ_PORTS  = 2,
   parameter int unsigned NR_WRITE_PORTS = 2,
   parameter bit          ZERO_REG_ZERO  = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      test_en_i,
   input  logic [4:0]                raddr_i [NR_READ_PORTS],
   output logic [DATA_WIDTH-1:0]     rdata_o [NR_READ_PORTS],
   input  logic [4:0]                waddr_i [NR_WRITE_PORTS],
   input  logic [DATA_WIDTH-1:0]     wdata_i [NR_WRITE_PORTS],
   input  logic [NR_WRITE_PORTS-1:0] we_i
);

   localparam int unsigned NUM_WORDS = 32;

   logic [DATA_WIDTH-1:0] r_mem       [NUM_WORDS];
   logic [NUM_WORDS-1:0]  w_reg_we;
   logic [DATA_WIDTH-1:0] w_reg_wdata [NUM_WORDS];
   logic                  w_unused;

   // test_en_i only exists for pin compatibility with the latch-based variant.
   assign w_unused = test_en_i;

   // Per-register write decode; ports are scanned in ascending order so the
   // highest-indexed enabled port overrides lower ones on the same address.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred;
      // blocking assignments here let later loop iterations override earlier ones.
      w_reg_we = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         w_reg_wdata[i] = '0;
      end
      for (int w = 0; w < NR_WRITE_PORTS; w++) begin
         if (we_i[w]) begin
            w_reg_we[waddr_i[w]]    = 1'b1;
            w_reg_wdata[waddr_i[w]] = wdata_i[w];
         end
      end
      if (ZERO_REG_ZERO) begin
         w_reg_we[0] = 1'b0;
      end
   end

   // NOTE: this storage is architectural state that must read 0 after reset, so unlike a
   // plain data RAM every word is cleared; non-blocking assignments for all sequential state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (w_reg_we[i]) begin
               r_mem[i] <= w_reg_wdata[i];
            end
         end
      end
   end

   // No write-to-read bypass: reads always see the currently stored value.
   always_comb begin
      for (int r = 0; r < NR_READ_PORTS; r++) begin
         if (ZERO_REG_ZERO && (raddr_i[r] == 5'd0)) begin
            rdata_o[r] = '0;
         end else begin
            rdata_o[r] = r_mem[raddr_i[r]];
         end
      end
   end

endmodule

// File: tb/tb_ariane_regfile_ff.sv
// Self-checking bench for ariane_regfile_ff: directed cases plus random traffic checked
// against an array model, with one instance per ZERO_REG_ZERO setting sharing all inputs.
module tb_ariane_regfile_ff;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        test_en;
   logic [4:0]  raddr   [2];
   logic [4:0]  waddr   [2];
   logic [31:0] wdata   [2];
   logic [1:0]  we;
   logic [31:0] rdata_z0 [2];
   logic [31:0] rdata_z1 [2];

   logic [31:0] model0 [32];
   logic [31:0] model1 [32];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ariane_regfile_ff #(.DATA_WIDTH(32), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2), .ZERO_REG_ZERO(1'b0)) dut_z0 (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
      .raddr_i(raddr), .rdata_o(rdata_z0),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we)
   );

   ariane_regfile_ff #(.DATA_WIDTH(32), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2), .ZERO_REG_ZERO(1'b1)) dut_z1 (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
      .raddr_i(raddr), .rdata_o(rdata_z1),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         model0[i] = '0;
         model1[i] = '0;
      end
   endtask

   // Ports applied in order, so a later port simply overwrites an earlier one.
   task automatic model_write();
      for (int w = 0; w < 2; w++) begin
         if (we[w]) begin
            model0[waddr[w]] = wdata[w];
            if (waddr[w] != 5'd0) model1[waddr[w]] = wdata[w];
         end
      end
   endtask

   task automatic do_cycle();
      @(posedge clk);
      if (rst_n) model_write();
      #1;
   endtask

   task automatic read_check(input string tag, input logic [4:0] a0, input logic [4:0] a1);
      raddr[0] = a0;
      raddr[1] = a1;
      #1;
      check({tag, "_z0_p0"}, rdata_z0[0], model0[a0]);
      check({tag, "_z0_p1"}, rdata_z0[1], model0[a1]);
      check({tag, "_z1_p0"}, rdata_z1[0], (a0 == 5'd0) ? 32'd0 : model1[a0]);
      check({tag, "_z1_p1"}, rdata_z1[1], (a1 == 5'd0) ? 32'd0 : model1[a1]);
   endtask

   task automatic drive(input logic [1:0] e, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
      we = e;
      waddr[0] = a0; wdata[0] = d0;
      waddr[1] = a1; wdata[1] = d1;
   endtask

   initial begin
      rst_n   = 1'b0;
      test_en = 1'b0;
      raddr[0] = '0; raddr[1] = '0;
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      model_clear();

      repeat (2) @(posedge clk);
      #1;
      read_check("rst_initial", 5'd0, 5'd31);
      rst_n = 1'b1;

      // Arbitrary prior contents, then an asynchronous reset pulse mid-cycle.
      for (int c = 0; c < 20; c++) begin
         drive(2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom);
         do_cycle();
      end
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      #2;
      rst_n = 1'b0;
      model_clear();
      read_check("rst_pulse_0_1", 5'd0, 5'd1);
      read_check("rst_pulse_31", 5'd31, 5'd31);

      // Writes held during reset across an edge are discarded.
      drive(2'b11, 5'd0, 32'h2, 5'd0, 32'h2);
      do_cycle();
      read_check("wr_in_rst", 5'd0, 5'd0);
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      rst_n = 1'b1;
      read_check("after_rst", 5'd0, 5'd1);

      // Basic write/read, one port at a time.
      drive(2'b01, 5'd1, 32'h2, 5'd0, '0);
      do_cycle();
      drive(2'b10, 5'd0, '0, 5'd2, 32'h14);
      do_cycle();
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      read_check("basic", 5'd1, 5'd2);
      check("basic_lit_p1", rdata_z0[1], 32'h14);
      check("basic_lit_p0", rdata_z0[0], 32'h2);

      // Dual write to different addresses.
      drive(2'b11, 5'd3, 32'hAAAA5555, 5'd4, 32'h12345678);
      do_cycle();
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      read_check("dual", 5'd3, 5'd4);
      check("dual_lit_r3", rdata_z0[0], 32'hAAAA5555);
      check("dual_lit_r4", rdata_z0[1], 32'h12345678);

      // Conflict: highest port wins.
      drive(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222);
      do_cycle();
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      read_check("conflict", 5'd7, 5'd7);
      check("conflict_lit", rdata_z0[0], 32'h2222);

      // Zero register behaviour for both settings.
      drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, '0);
      do_cycle();
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      read_check("zero_reg", 5'd0, 5'd0);
      check("zero_lit_z0", rdata_z0[0], 32'hFFFFFFFF);
      check("zero_lit_z1", rdata_z1[0], 32'h0);

      // No bypass: pending write invisible until the edge.
      drive(2'b01, 5'd9, 32'h5, 5'd0, '0);
      read_check("nobypass_pre", 5'd9, 5'd9);
      check("nobypass_pre_lit", rdata_z0[0], 32'h0);
      do_cycle();
      drive(2'b00, 5'd0, '0, 5'd0, '0);
      read_check("nobypass_post", 5'd9, 5'd9);
      check("nobypass_post_lit", rdata_z0[0], 32'h5);

      // Random traffic with frequent address collisions and reads before/after each edge.
      for (int c = 0; c < 300; c++) begin
         logic [4:0] a0, a1;
         a0 = 5'($urandom);
         a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
         drive(2'($urandom), a0, $urandom, a1, $urandom);
         read_check("rand_pre", 5'($urandom), a0);
         do_cycle();
         read_check("rand_post", a0, a1);
         if (c == 150) begin
            rst_n = 1'b0;
            model_clear();
            read_check("rand_rst", a0, a1);
            rst_n = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ariane_regfile_ff.md
# ariane_regfile_ff

Flip-flop based, multi-ported integer register file: 32 architectural registers, `DATA_WIDTH` bits each. Used as the core's scoreboard-side register file. Provides `NR_READ_PORTS` combinational read ports and `NR_WRITE_PORTS` synchronous write ports. Register x0 is optionally hardwired to zero.

## Interface
- `DATA_WIDTH`, default 32: width of each register and data port.
- `NR_READ_PORTS`, default 2: number of independent read ports, at least 1.
- `NR_WRITE_PORTS`, default 2: number of independent write ports, at least 1.
- `ZERO_REG_ZERO`, default 0: when 1, register 0 always reads 0 and ignores writes.
- `clk_i` input, 1 bit: single clock, rising-edge active.
- `rst_ni` input, 1 bit: reset, asynchronous and active-low.
- `test_en_i` input, 1 bit: test/scan enable. Kept for interface compatibility with the latch variant; no functional effect.
- `raddr_i` input, `NR_READ_PORTS`×5 bits: read address per port.
- `rdata_o` output, `NR_READ_PORTS`×`DATA_WIDTH` bits: read data per port.
- `waddr_i` input, `NR_WRITE_PORTS`×5 bits: write address per port.
- `wdata_i` input, `NR_WRITE_PORTS`×`DATA_WIDTH` bits: write data per port.
- `we_i` input, `NR_WRITE_PORTS` bits: write enable per port.

## Operation
- Storage is 32 × `DATA_WIDTH` flops, indexed 0..31 by the 5-bit address.
- **Reset:** while `rst_ni`=0, all 32 registers are cleared to 0.
  - Reset dominates: writes presented during reset are discarded.
  - Consequently every `rdata_o` reads 0 during and directly after reset.
- **Write:** on each rising edge of `clk_i` with `rst_ni`=1, for each port w with `we_i[w]`=1, register `waddr_i[w]` is loaded with `wdata_i[w]`.
  - Registers not addressed by any enabled port hold their value.
- **Write conflict:** if two or more enabled ports address the same register in the same cycle, the highest-indexed port wins. Example: ports 0 and 1 both write reg 5, so reg 5 takes `wdata_i[1]`.
- **Zero register:**
  - `ZERO_REG_ZERO`=1: reg 0 is never written; reading address 0 always returns 0.
  - `ZERO_REG_ZERO`=0: reg 0 behaves like any other register.
- **Read:** `rdata_o[r]` equals register `raddr_i[r]`, purely combinationally.
  - There is no write-to-read bypass. A value written on edge N becomes visible on reads only after edge N.
  - Multiple read ports may address the same register simultaneously.
- All address values 0..31 are valid; there is no out-of-range condition.

## Timing
- Read latency: 0 cycles (combinational from `raddr_i` and register state).
- Write latency: 1 cycle. Data is captured at the rising edge and visible on `rdata_o` right after that edge.
- Reset is asynchronous assertion; registers clear without a clock.
- Deassertion is synchronous to the next `clk_i` edge. The first write is taken on the first rising edge with `rst_ni`=1.
- Reset asserted mid-operation clears all state immediately. Any write in that cycle is lost.
- No handshakes or stalls: one write per port per cycle, unlimited reads.

## Test plan
- **Reset:** pulse `rst_ni` low with arbitrary prior contents, then read regs 0, 1 and 31 on both ports. Required: all read 0.
- **Basic write/read:**
  - Cycle 1: `we_i`=2'b01, `waddr_i[0]`=1, `wdata_i[0]`=0x2.
  - Cycle 2: `we_i`=2'b10, `waddr_i[1]`=2, `wdata_i[1]`=0x14.
  - Then `raddr_i`={2,1}. Required: `rdata_o[1]`=0x14, `rdata_o[0]`=0x2.
- **Dual write, different addresses:** one cycle writing reg 3=0xAAAA5555 (port 0) and reg 4=0x12345678 (port 1). Required: both values read back after the edge, regs 3 and 4 read simultaneously.
- **Write conflict:** both ports write reg 7 in one cycle, port 0=0x1111 and port 1=0x2222. Required: reg 7 reads 0x2222.
- **Zero register:**
  - `ZERO_REG_ZERO`=1, write 0xFFFFFFFF to reg 0. Required: reg 0 reads 0.
  - `ZERO_REG_ZERO`=0, same write. Required: reg 0 reads 0xFFFFFFFF.
- **Write during reset / no bypass:**
  - Hold `rst_ni`=0 with `we_i`=2'b11 writing reg 0=0x2. Required: reg 0 reads 0.
  - Normal write of 0x5 to reg 9: before the edge, read of reg 9 shows the old value; after the edge it shows 0x5.
